// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx byte transmitter among NREQ
// requesters, with optional source-ID header and forced close at MAX_LEN payload bytes.
module uart_tx_arbiter #(
   parameter int         NREQ     = 4,
   parameter int         HDR_EN   = 1,
   parameter logic [7:0] HDR_BASE = 8'hA0,
   parameter int         MAX_LEN  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              trunc
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t          state_reg;
   logic [IDXW-1:0] gidx_reg;
   logic [IDXW-1:0] ptr_reg;
   logic [7:0]      cnt_reg;
   logic            trunc_reg;

   logic [7:0]      req_byte [NREQ];
   logic [IDXW-1:0] pick_idx;
   logic            pick_found;
   logic [IDXW-1:0] gidx_inc;
   logic            xfer;
   logic            owner_last;
   logic            at_limit;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_byte[gi]  = req_data[8*gi +: 8];
         assign req_ready[gi] = (state_reg == DATA) && (gidx_reg == IDXW'(gi)) && tx_ready;
         assign grant[gi]     = (state_reg != IDLE) && (gidx_reg == IDXW'(gi));
      end
   endgenerate

   // Scan downward in priority so the nearest asserted index at or after ptr wins last.
   always_comb begin : arb_pick
      int j;
      pick_found = 1'b0;
      pick_idx   = ptr_reg;
      j          = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(ptr_reg) + k;
         if (j >= NREQ) j = j - NREQ;
         if (req_valid[j[IDXW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = j[IDXW-1:0];
         end
      end
   end

   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      case (state_reg)
         HDR: begin
            tx_valid = 1'b1;
            tx_data  = HDR_BASE | 8'(gidx_reg);
         end
         DATA: begin
            tx_valid = req_valid[gidx_reg];
            tx_data  = req_byte[gidx_reg];
         end
         default: ;
      endcase
   end

   assign xfer       = (state_reg == DATA) && tx_valid && tx_ready;
   assign owner_last = req_last[gidx_reg];
   assign at_limit   = (cnt_reg == 8'(MAX_LEN - 1));
   assign gidx_inc   = (gidx_reg == IDXW'(NREQ - 1)) ? '0 : gidx_reg + 1'b1;
   assign busy       = (state_reg != IDLE);
   assign trunc      = trunc_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         gidx_reg  <= '0;
         ptr_reg   <= '0;
         cnt_reg   <= 8'd0;
         trunc_reg <= 1'b0;
      end else begin
         trunc_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pick_found) begin
                  gidx_reg  <= pick_idx;
                  cnt_reg   <= 8'd0;
                  state_reg <= (HDR_EN != 0) ? HDR : DATA;
               end
            end
            HDR: begin
               if (tx_ready) state_reg <= DATA;
            end
            DATA: begin
               if (xfer) begin
                  cnt_reg <= cnt_reg + 8'd1;
                  if (owner_last || at_limit) begin
                     state_reg <= IDLE;
                     ptr_reg   <= gidx_inc;
                     trunc_reg <= !owner_last;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester source queues drive the DUT,
// expected transmitter bytes are queued at stimulus time and checked by a monitor.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         gap;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [8*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   req_last = '0;
   logic [NREQ-1:0]   req_ready;
   logic              tx_valid;
   logic [7:0]        tx_data;
   logic              tx_ready = 1'b1;
   logic [NREQ-1:0]   grant;
   logic              busy;
   logic              trunc;

   ent_t       src_q [NREQ][$];
   logic [7:0] exp_q [$];
   int         gap_cnt [NREQ];
   logic [NREQ-1:0] acc = '0;
   logic       bp_mode = 1'b0;
   logic       stall_prev = 1'b0;
   logic [7:0] prev_data = 8'h00;
   int         trunc_seen = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   uart_tx_arbiter #(
      .NREQ(NREQ), .HDR_EN(1), .HDR_BASE(8'hA0), .MAX_LEN(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .grant(grant), .busy(busy), .trunc(trunc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic put(input int r, input logic [7:0] d, input logic l, input int g);
      ent_t e;
      e.data = d;
      e.last = l;
      e.gap  = g;
      src_q[r].push_back(e);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
             src_q[3].size() == 0 && exp_q.size() == 0 && !busy)
            return;
      end
      n_chk++;
      n_fail++;
      $display("FAIL %s: drain timeout, %0d bytes outstanding, required 0", name, exp_q.size());
   endtask

   // Record requester-side acceptances away from the edge; drivers act on them after it.
   always @(negedge clk) begin
      for (int i = 0; i < NREQ; i++) acc[i] = req_valid[i] && req_ready[i] && !rst;
   end

   always @(posedge clk) begin
      ent_t e;
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i] && src_q[i].size() > 0) begin
            e = src_q[i].pop_front();
            if (src_q[i].size() > 0) gap_cnt[i] = src_q[i][0].gap;
         end
         if (gap_cnt[i] > 0) begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            gap_cnt[i]--;
         end else if (src_q[i].size() > 0) begin
            req_valid[i]        = 1'b1;
            req_data[8*i +: 8]  = src_q[i][0].data;
            req_last[i]         = src_q[i][0].last;
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
      tx_ready = bp_mode ? !tx_ready : 1'b1;
   end

   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst) begin
         if (stall_prev) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data", 32'(tx_data), 32'(prev_data));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_xfer: got %02h, required no transfer", tx_data);
            end else begin
               e = exp_q.pop_front();
               $display("xfer tx_data=%02h expected=%02h grant=%b", tx_data, e, grant);
               check("tx_byte", 32'(tx_data), 32'(e));
            end
         end
         if (trunc) trunc_seen++;
         stall_prev = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      for (int i = 0; i < NREQ; i++) gap_cnt[i] = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_trunc", 32'(trunc), 32'd0);

      // Round-robin: req0 holds two packets, others one each.
      put(0, 8'h10, 1'b1, 0); put(0, 8'h14, 1'b1, 0);
      put(1, 8'h11, 1'b1, 0); put(2, 8'h12, 1'b1, 0); put(3, 8'h13, 1'b1, 0);
      exp_q = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 8'hA0, 8'h14};
      drain("round_robin");

      // Single packet on req1, grant held 1+3 cycles.
      put(1, 8'h11, 1'b0, 0); put(1, 8'h22, 1'b0, 0); put(1, 8'h33, 1'b1, 0);
      exp_q = '{8'hA1, 8'h11, 8'h22, 8'h33};
      @(negedge clk);
      check("single_grant_pre", 32'(grant), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("single_grant", 32'(grant), 32'b0010);
      end
      @(negedge clk);
      check("single_grant_post", 32'(grant), 32'd0);
      check("single_gap_valid", 32'(tx_valid), 32'd0);
      drain("single");

      // No interleave: req0 pauses two cycles mid-packet, req2 waits.
      put(0, 8'h41, 1'b0, 0); put(0, 8'h42, 1'b0, 0);
      put(0, 8'h43, 1'b0, 2); put(0, 8'h44, 1'b1, 0);
      exp_q = '{8'hA0, 8'h41, 8'h42, 8'h43, 8'h44, 8'hA2, 8'h71};
      repeat (2) @(negedge clk);
      put(2, 8'h71, 1'b1, 0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("gap_tx_valid", 32'(tx_valid), 32'd0);
         check("gap_grant", 32'(grant), 32'b0001);
         @(negedge clk);
      end
      drain("no_interleave");

      // Backpressure on header and payload.
      bp_mode = 1'b1;
      put(3, 8'h81, 1'b0, 0); put(3, 8'h82, 1'b0, 0); put(3, 8'h83, 1'b1, 0);
      exp_q = '{8'hA3, 8'h81, 8'h82, 8'h83};
      drain("backpressure");
      bp_mode = 1'b0;
      repeat (2) @(negedge clk);

      // Truncation at MAX_LEN=4: six bytes become 4 + 2 with a second header.
      for (int k = 0; k < 6; k++) put(3, 8'(8'h61 + k), (k == 5), 0);
      exp_q = '{8'hA3, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA3, 8'h65, 8'h66};
      repeat (7) @(negedge clk);
      check("trunc_pulse", 32'(trunc), 32'd1);
      check("trunc_idle", 32'(busy), 32'd0);
      check("trunc_idle_valid", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check("trunc_clear", 32'(trunc), 32'd0);
      check("trunc_regrant", 32'(grant), 32'b1000);
      drain("truncation");

      // Leave ptr at 2, then reset in the middle of a req2 packet.
      put(1, 8'h91, 1'b1, 0);
      exp_q = '{8'hA1, 8'h91};
      drain("pre_reset");
      put(2, 8'h51, 1'b0, 0); put(2, 8'h52, 1'b0, 0);
      put(2, 8'h53, 1'b0, 0); put(2, 8'h54, 1'b1, 0);
      exp_q = '{8'hA2, 8'h51, 8'h52};
      repeat (4) @(negedge clk);
      #1;
      rst = 1'b1;
      src_q[2].delete();
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_grant", 32'(grant), 32'd0);
      check("midrst_tx_valid", 32'(tx_valid), 32'd0);
      check("midrst_sent", 32'(exp_q.size()), 32'd0);
      put(1, 8'hB1, 1'b1, 0); put(3, 8'hB3, 1'b1, 0);
      exp_q = '{8'hA1, 8'hB1, 8'hA3, 8'hB3};
      drain("post_reset");

      check("trunc_count", 32'(trunc_seen), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
